fifo_input_packer: RTL and testbench
====================================

# fifo_input_packer

Upstream width-packing stage for the MIG-based FIFO input. It accepts narrow AXI-Stream samples and packs `R = MIG_Port_Size/In_Width` samples into one `MIG_Port_Size` word, which feeds the FIFO's `indata_*` port. Partial words are flushed and zero-padded on `s_tlast`, or after a programmable idle timeout. This keeps low-rate streams from stalling inside the packer.

## Interface
Parameters:
- `In_Width`, 32, input sample width. `MIG_Port_Size/In_Width` must be a power of two ≥ 2.
- `MIG_Port_Size`, 128, output word width. Legal values: 64/128/256/512.
- `Flush_Timeout`, 256, idle cycles before a partial word is flushed. 0 disables the timeout; range 0..65535.

Ports:
- `aclk`  in  1  clock.
- `areset`  in  1  reset. Synchronous, active-high.
- `s_tdata`  in  `In_Width`  input sample.
- `s_tvalid`  in  1  sample valid.
- `s_tready`  out  1  sample ready.
- `s_tlast`  in  1  end of burst; forces a flush after this sample.
- `m_tdata`  out  `MIG_Port_Size`  packed word, to the FIFO `indata_tdata`.
- `m_tvalid`  out  1  packed word valid.
- `m_tready`  in  1  from the FIFO `indata_tready`.
- `words_out`  out  32  count of completed `m_*` handshakes; wraps.
- `padded_words`  out  32  count of partial (padded) words generated; wraps.

## Operation
- Internal state:
  - assembly register `asm` (`MIG_Port_Size` bits)
  - lane index `idx` (`log2(R)` bits)
  - idle timer (16 bits)
  - output register `m_tdata`/`m_tvalid`
- The output slot is free when `!m_tvalid || m_tready`.
- `s_tready` equals "output slot free" and `!areset`.
- Accepted beat (`s_tvalid && s_tready`):
  - The sample is written to lane `idx`, bits `[idx*In_Width +: In_Width]`. The first sample lands in the LSBs.
- Completing beat: an accepted beat with `idx == R-1` or `s_tlast == 1`.
  - The output register loads `asm` with the current sample merged in lane `idx`.
  - All lanes above `idx` are zero.
  - `m_tvalid` is set to 1 and `idx` returns to 0.
  - If `idx < R-1`, `padded_words` increments.
- Non-completing accepted beat: `idx` increments and the timer clears.
- Any accepted beat clears the timer.
- Idle timer behaviour:
  - Increments on each cycle with `idx != 0` and no accepted beat.
  - Held at 0 while `idx == 0`.
- Timeout flush fires when all of the following hold:
  - `Flush_Timeout != 0`
  - `idx != 0`
  - the timer has reached `Flush_Timeout`
  - the output slot is free
- On a timeout flush: `asm` is loaded with its upper lanes zeroed, `padded_words` increments, and `idx` and the timer clear.
- If the slot is busy, the flush waits; the timer saturates and does not wrap.
- Simultaneous accepted beat and timeout: the beat wins. It is packed normally, the timer clears and no flush occurs.
- The `s_tlast` case where `idx == R-1` is a full word: no padding and no `padded_words` increment.
- On an `m_*` handshake with no new load, `m_tvalid` goes to 0. `words_out` increments on every `m_tvalid && m_tready`.
- `m_tdata` holds stable while `m_tvalid && !m_tready`.

## Timing
- Reset values, with `areset` sampled high at an `aclk` edge:
  - `m_tvalid` = 0
  - `m_tdata` = 0
  - `words_out` = 0
  - `padded_words` = 0
  - `idx` = 0
  - timer = 0
  - `asm` = 0
- `s_tready` is 0 while `areset` is high.
- A partial word present at reset is discarded and never emitted.
- Latency: a completing beat accepted in cycle N gives `m_tvalid` = 1 in cycle N+1.
- Throughput: one sample per cycle sustained while `m_tready` = 1.
- Back-to-back words: the output register reloads in the same cycle as its handshake, with no bubble.
- Timeout: last beat accepted in cycle T, no beats in T+1..T+F (F = `Flush_Timeout`).
  - The flush loads at the end of cycle T+F.
  - `m_tvalid` = 1 in T+F+1, provided the slot is free.
- Backpressure: with `m_tvalid` = 1 and `m_tready` = 0, `s_tready` = 0. There is no input acceptance, even for non-completing lanes.

## Test plan
- **Continuous pack.** Params 32/128, `m_tready` = 1, beats 0x1..0x8 back-to-back. Required response:
  - `m_tdata` = 0x00000004_00000003_00000002_00000001 one cycle after beat 4.
  - Then 0x00000008_00000007_00000006_00000005.
  - `words_out` = 2, `padded_words` = 0.
- **Early tlast.** Beats 0xA, then 0xB with `s_tlast`. Required response:
  - `m_tdata` = 0x00000000_00000000_0000000B_0000000A.
  - `padded_words` = 1.
  - The next beat lands in lane 0.
- **Backpressure.** Hold `m_tready` = 0 after the first word. Required response:
  - `s_tready` = 0 and `m_tdata` stable for 20 cycles.
  - Release: all 8 words of a random 32-sample stream arrive in order with no loss or duplication.
- **Timeout.** `Flush_Timeout` = 16, beats 0x1, 0x2, 0x3, then idle. Required response:
  - `m_tvalid` rises exactly 17 cycles after the last beat's acceptance cycle, with word 0x00000000_00000003_00000002_00000001.
  - Repeat with `Flush_Timeout` = 0: no word is ever emitted.
- **Beat on timeout cycle.** Deliver beat 4 in cycle T+16. Required response:
  - No flush.
  - A full word 0x4_3_2_1 (lane layout as above) is emitted and `padded_words` is unchanged.
- **Reset mid-word.** Two beats, then `areset` pulsed for 1 cycle. Required response:
  - All outputs are 0 the following cycle.
  - The subsequent 4 beats form one clean word, with no stale lanes.

Source files
------------

// File: rtl/fifo_input_packer.sv
// ---------------------------------------------------------------------------
// fifo_input_packer
//
// Width-packing stage in front of the MIG-based FIFO input. Narrow
// AXI-Stream samples are gathered into one MIG_Port_Size word,
// Lanes = MIG_Port_Size/In_Width samples per word. The first sample of a
// word lands in the least significant lane.
//
// A partial word is zero-padded and emitted early in two cases:
//   - the sample carries s_tlast
//   - the input has been idle for Flush_Timeout cycles (0 disables this)
// The idle flush keeps slow streams from sitting inside the packer.
//
// Ports:
//   aclk          clock
//   areset        synchronous active-high reset
//   s_tdata       input sample (In_Width bits)
//   s_tvalid      input sample valid
//   s_tready      input ready: output slot free and not in reset
//   s_tlast       end of burst; the word is closed after this sample
//   m_tdata       packed word (MIG_Port_Size bits), to FIFO indata_tdata
//   m_tvalid      packed word valid
//   m_tready      from FIFO indata_tready
//   words_out     count of completed m_* handshakes (wraps)
//   padded_words  count of zero-padded partial words generated (wraps)
// ---------------------------------------------------------------------------
module fifo_input_packer #(
  parameter int In_Width      = 32,
  parameter int MIG_Port_Size = 128,
  parameter int Flush_Timeout = 256
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [In_Width-1:0]      s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  output logic [MIG_Port_Size-1:0] m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [31:0]              words_out,
  output logic [31:0]              padded_words
);

  localparam int Lanes = MIG_Port_Size / In_Width;
  localparam int IdxW  = $clog2(Lanes);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(Lanes - 1);

  // The idle timer holds the number of idle cycles completed before the
  // current one, so the flush fires while it reads Flush_Timeout-1: the
  // current cycle is then the Flush_Timeout-th idle cycle.
  localparam bit          TimeoutEn     = (Flush_Timeout != 0);
  localparam logic [15:0] TimeoutThresh = (Flush_Timeout == 0) ? 16'd0
                                          : 16'(Flush_Timeout - 1);

  // -------------------------------------------------------------------------
  // State registers and their next-state values
  // -------------------------------------------------------------------------
  logic [MIG_Port_Size-1:0] asm_q,         asm_d;
  logic [IdxW-1:0]          laneIdx_q,     laneIdx_d;
  logic [15:0]              idleTimer_q,   idleTimer_d;
  logic [MIG_Port_Size-1:0] mData_q,       mData_d;
  logic                     mValid_q,      mValid_d;
  logic [31:0]              wordsOut_q,    wordsOut_d;
  logic [31:0]              paddedWords_q, paddedWords_d;

  // -------------------------------------------------------------------------
  // Handshake and event decode
  // -------------------------------------------------------------------------
  logic slotFree;
  logic beatAccept;
  logic lastLane;
  logic beatCompletes;
  logic timeoutFire;
  logic outHandshake;

  // The output register can take a new word when it is empty or is being
  // drained this very cycle, which is what gives back-to-back words with no
  // bubble. Input acceptance follows the slot directly, so under
  // backpressure even non-completing lanes are held off.
  always_comb begin
    slotFree      = !mValid_q || m_tready;
    s_tready      = slotFree && !areset;
    beatAccept    = s_tvalid && s_tready;
    lastLane      = (laneIdx_q == LastIdx);
    beatCompletes = beatAccept && (lastLane || s_tlast);
    outHandshake  = mValid_q && m_tready;
    // An accepted beat takes priority over a timeout landing in the same
    // cycle: the sample is packed and the timer restarts instead.
    timeoutFire   = TimeoutEn && (laneIdx_q != '0) &&
                    (idleTimer_q >= TimeoutThresh) && slotFree && !beatAccept;
  end

  // -------------------------------------------------------------------------
  // Lane datapath
  // -------------------------------------------------------------------------
  logic [MIG_Port_Size-1:0] writtenWord;
  logic [MIG_Port_Size-1:0] mergedWord;
  logic [MIG_Port_Size-1:0] flushWord;

  // Three views of the assembly register:
  //   writtenWord - the sample dropped into the current lane (word still open)
  //   mergedWord  - the same, with every lane above the current one forced
  //                 to zero; this is the word emitted on a completing beat
  //   flushWord   - only the lanes already filled, used by the idle flush
  // The assembly register is cleared whenever a word leaves, so the upper
  // lanes are already zero; masking them anyway keeps padding exact even if
  // that ever changes.
  always_comb begin
    writtenWord = asm_q;
    mergedWord  = '0;
    flushWord   = '0;
    for (int l = 0; l < Lanes; l++) begin
      if (IdxW'(l) < laneIdx_q) begin
        mergedWord[l*In_Width +: In_Width] = asm_q[l*In_Width +: In_Width];
        flushWord[l*In_Width +: In_Width]  = asm_q[l*In_Width +: In_Width];
      end
      if (IdxW'(l) == laneIdx_q) begin
        mergedWord[l*In_Width +: In_Width]  = s_tdata;
        writtenWord[l*In_Width +: In_Width] = s_tdata;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------

  // Output handshake first, then a possible reload of the output register:
  // a load in the same cycle as a handshake overrides the drop of m_tvalid.
  // A completing beat and a timeout flush are mutually exclusive because the
  // flush is suppressed by any accepted beat.
  always_comb begin
    asm_d         = asm_q;
    laneIdx_d     = laneIdx_q;
    mData_d       = mData_q;
    mValid_d      = mValid_q;
    wordsOut_d    = wordsOut_q;
    paddedWords_d = paddedWords_q;

    if (outHandshake) begin
      mValid_d   = 1'b0;
      wordsOut_d = wordsOut_q + 32'd1;
    end

    if (beatCompletes) begin
      mData_d   = mergedWord;
      mValid_d  = 1'b1;
      asm_d     = '0;
      laneIdx_d = '0;
      if (!lastLane) begin
        paddedWords_d = paddedWords_q + 32'd1;
      end
    end else if (beatAccept) begin
      asm_d     = writtenWord;
      laneIdx_d = laneIdx_q + IdxW'(1);
    end else if (timeoutFire) begin
      mData_d       = flushWord;
      mValid_d      = 1'b1;
      asm_d         = '0;
      laneIdx_d     = '0;
      paddedWords_d = paddedWords_q + 32'd1;
    end
  end

  // The idle timer only runs while a partial word is open. It saturates so a
  // flush that is blocked by a busy output slot stays armed instead of
  // wrapping back below the threshold.
  always_comb begin
    idleTimer_d = idleTimer_q;
    if (beatAccept || timeoutFire || (laneIdx_q == '0)) begin
      idleTimer_d = 16'd0;
    end else if (idleTimer_q != 16'hFFFF) begin
      idleTimer_d = idleTimer_q + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------

  // Synchronous reset throws away any partially assembled word along with
  // the output register and both counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      asm_q         <= '0;
      laneIdx_q     <= '0;
      idleTimer_q   <= 16'd0;
      mData_q       <= '0;
      mValid_q      <= 1'b0;
      wordsOut_q    <= 32'd0;
      paddedWords_q <= 32'd0;
    end else begin
      asm_q         <= asm_d;
      laneIdx_q     <= laneIdx_d;
      idleTimer_q   <= idleTimer_d;
      mData_q       <= mData_d;
      mValid_q      <= mValid_d;
      wordsOut_q    <= wordsOut_d;
      paddedWords_q <= paddedWords_d;
    end
  end

  assign m_tdata      = mData_q;
  assign m_tvalid     = mValid_q;
  assign words_out    = wordsOut_q;
  assign padded_words = paddedWords_q;

endmodule

// File: tb/tb_fifo_input_packer.sv
// ---------------------------------------------------------------------------
// tb_fifo_input_packer
//
// Self-checking bench for fifo_input_packer (32-bit samples, 128-bit words).
// The main instance uses a 16-cycle idle flush; a second instance with the
// flush disabled shows that a partial word then stays inside the packer.
// Expected words are queued when stimulus is issued and a monitor pops and
// compares them on every output handshake.
// ---------------------------------------------------------------------------
module tb_fifo_input_packer;

  localparam int InW           = 32;
  localparam int OutW          = 128;
  localparam int TimeoutCycles = 16;

  logic            aclk = 1'b0;
  logic            areset;
  logic [InW-1:0]  s_tdata;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic [OutW-1:0] m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic [31:0]     words_out;
  logic [31:0]     padded_words;

  logic [InW-1:0]  zeroTdata;
  logic            zeroTvalid;
  logic            zeroTready;
  logic            zeroTlast;
  logic [OutW-1:0] zeroMdata;
  logic            zeroMvalid;
  logic [31:0]     zeroWordsOut;
  logic [31:0]     zeroPadded;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastAcceptCyc = 0;
  int zeroValidSeen = 0;
  int waitValidCnt = 0;
  int timeoutStart = 0;
  int throughputStart = 0;

  logic [OutW-1:0] expQ[$];
  logic [InW-1:0]  samples[32];
  logic [OutW-1:0] heldWord;

  fifo_input_packer #(
    .In_Width      (InW),
    .MIG_Port_Size (OutW),
    .Flush_Timeout (TimeoutCycles)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .words_out    (words_out),
    .padded_words (padded_words)
  );

  fifo_input_packer #(
    .In_Width      (InW),
    .MIG_Port_Size (OutW),
    .Flush_Timeout (0)
  ) dutNoTimeout (
    .aclk         (aclk),
    .areset       (areset),
    .s_tdata      (zeroTdata),
    .s_tvalid     (zeroTvalid),
    .s_tready     (zeroTready),
    .s_tlast      (zeroTlast),
    .m_tdata      (zeroMdata),
    .m_tvalid     (zeroMvalid),
    .m_tready     (1'b1),
    .words_out    (zeroWordsOut),
    .padded_words (zeroPadded)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 aclk = ~aclk;

  // Cycle counter used for latency and throughput measurements.
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [OutW-1:0] actual,
                             input logic [OutW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportExpired(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  // Present one sample and hold it until the packer takes it. Inputs change
  // just after a rising edge and s_tready is sampled on the falling edge, so
  // the value seen there is what the DUT sees at the next rising edge.
  task automatic applyStimulus(input logic [InW-1:0] data, input logic last);
    int waited = 0;
    s_tdata  = data;
    s_tlast  = last;
    s_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_tready) break;
      waited++;
      if (waited > 200) begin
        reportExpired("s_tready wait");
        break;
      end
    end
    @(posedge aclk);
    #1;
    s_tvalid      = 1'b0;
    s_tlast       = 1'b0;
    lastAcceptCyc = cyc;
  endtask

  task automatic waitDrain(input string name);
    int k = 0;
    while (expQ.size() != 0 && k < 300) begin
      @(negedge aclk);
      k++;
    end
    if (expQ.size() != 0) reportExpired(name);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  // Scoreboard monitor: every output handshake must match the oldest
  // expected word; a word with nothing queued is itself an error.
  always @(negedge aclk) begin
    if (!areset && m_tvalid && m_tready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected word: got 0x%0h, expected no word", m_tdata);
      end else begin
        checkOutput("scoreboard word", m_tdata, expQ.pop_front());
      end
    end
  end

  // Counts any word produced by the instance with the idle flush disabled.
  always @(negedge aclk) begin
    if (!areset && zeroMvalid) zeroValidSeen <= zeroValidSeen + 1;
  end

  // Global guard so a stuck handshake can never hang the run.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    areset     = 1'b1;
    s_tdata    = '0;
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    m_tready   = 1'b1;
    zeroTdata  = '0;
    zeroTvalid = 1'b0;
    zeroTlast  = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkOutput("s_tready in reset", OutW'(s_tready), '0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    checkOutput("reset m_tvalid", OutW'(m_tvalid), '0);
    checkOutput("reset m_tdata", m_tdata, '0);
    checkOutput("reset words_out", OutW'(words_out), '0);
    checkOutput("reset padded_words", OutW'(padded_words), '0);

    // Continuous pack: 8 beats back-to-back, one word per 4 beats
    $display("[TB] continuous pack");
    expQ.push_back(128'h00000004_00000003_00000002_00000001);
    expQ.push_back(128'h00000008_00000007_00000006_00000005);
    throughputStart = cyc;
    for (int i = 1; i <= 4; i++) applyStimulus(InW'(i), 1'b0);
    checkOutput("latency m_tvalid", OutW'(m_tvalid), 128'd1);
    checkOutput("latency m_tdata", m_tdata, 128'h00000004_00000003_00000002_00000001);
    for (int i = 5; i <= 8; i++) applyStimulus(InW'(i), 1'b0);
    checkOutput("throughput cycles", OutW'(cyc - throughputStart), 128'd8);
    waitDrain("continuous drain");
    checkOutput("continuous words_out", OutW'(words_out), 128'd2);
    checkOutput("continuous padded_words", OutW'(padded_words), 128'd0);

    // Early tlast pads the word; the following beat restarts at lane 0
    $display("[TB] early tlast");
    expQ.push_back(128'h00000000_00000000_0000000B_0000000A);
    expQ.push_back(128'h0000000F_0000000E_0000000D_0000000C);
    applyStimulus(32'hA, 1'b0);
    applyStimulus(32'hB, 1'b1);
    applyStimulus(32'hC, 1'b0);
    applyStimulus(32'hD, 1'b0);
    applyStimulus(32'hE, 1'b0);
    applyStimulus(32'hF, 1'b0);
    waitDrain("tlast drain");
    checkOutput("tlast words_out", OutW'(words_out), 128'd4);
    checkOutput("tlast padded_words", OutW'(padded_words), 128'd1);

    // Backpressure: output stalled for 20 cycles, then a 32-sample stream
    $display("[TB] backpressure");
    for (int i = 0; i < 32; i++) samples[i] = $urandom;
    for (int w = 0; w < 8; w++)
      expQ.push_back({samples[4*w+3], samples[4*w+2], samples[4*w+1], samples[4*w]});
    m_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) applyStimulus(samples[i], 1'b0);
      end
      begin
        waitValidCnt = 0;
        while (!m_tvalid && waitValidCnt < 100) begin
          @(negedge aclk);
          waitValidCnt++;
        end
        if (!m_tvalid) reportExpired("backpressure first word");
        heldWord = m_tdata;
        repeat (20) begin
          @(negedge aclk);
          checkOutput("stall s_tready", OutW'(s_tready), '0);
          checkOutput("stall m_tdata", m_tdata, heldWord);
        end
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
      end
    join
    waitDrain("backpressure drain");
    checkOutput("backpressure words_out", OutW'(words_out), 128'd12);
    checkOutput("backpressure padded_words", OutW'(padded_words), 128'd1);

    // Idle timeout: the flushed word appears in cycle T+17
    $display("[TB] idle timeout");
    expQ.push_back(128'h00000000_00000003_00000002_00000001);
    applyStimulus(32'h1, 1'b0);
    applyStimulus(32'h2, 1'b0);
    applyStimulus(32'h3, 1'b0);
    timeoutStart = lastAcceptCyc;
    waitValidCnt = 0;
    while (!m_tvalid && waitValidCnt < 60) begin
      @(negedge aclk);
      waitValidCnt++;
    end
    if (m_tvalid) checkOutput("timeout latency", OutW'(cyc - timeoutStart), 128'd16);
    else reportExpired("timeout flush");
    waitDrain("timeout drain");
    checkOutput("timeout words_out", OutW'(words_out), 128'd13);
    checkOutput("timeout padded_words", OutW'(padded_words), 128'd2);

    // Beat arriving in the cycle the flush would fire wins over the flush
    $display("[TB] beat on timeout cycle");
    expQ.push_back(128'h00000004_00000003_00000002_00000001);
    applyStimulus(32'h1, 1'b0);
    applyStimulus(32'h2, 1'b0);
    applyStimulus(32'h3, 1'b0);
    repeat (15) @(posedge aclk);
    #1;
    applyStimulus(32'h4, 1'b0);
    waitDrain("race drain");
    repeat (20) @(posedge aclk);
    #1;
    checkOutput("race words_out", OutW'(words_out), 128'd14);
    checkOutput("race padded_words", OutW'(padded_words), 128'd2);

    // Flush disabled: a partial word waits indefinitely, tlast still closes it
    $display("[TB] timeout disabled");
    zeroTvalid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      zeroTdata = InW'(i);
      @(posedge aclk);
      #1;
    end
    zeroTvalid = 1'b0;
    repeat (100) @(posedge aclk);
    #1;
    checkOutput("no-timeout words seen", OutW'(zeroValidSeen), '0);
    checkOutput("no-timeout padded_words", OutW'(zeroPadded), '0);
    zeroTdata  = 32'h4;
    zeroTlast  = 1'b1;
    zeroTvalid = 1'b1;
    @(posedge aclk);
    #1;
    zeroTvalid = 1'b0;
    zeroTlast  = 1'b0;
    checkOutput("no-timeout tlast m_tvalid", OutW'(zeroMvalid), 128'd1);
    checkOutput("no-timeout tlast m_tdata", zeroMdata, 128'h00000004_00000003_00000002_00000001);
    checkOutput("no-timeout tlast padded", OutW'(zeroPadded), '0);

    // Reset mid-word discards the partial word and clears all outputs
    $display("[TB] reset mid-word");
    applyStimulus(32'h11, 1'b0);
    applyStimulus(32'h22, 1'b0);
    areset = 1'b1;
    @(negedge aclk);
    checkOutput("mid reset s_tready", OutW'(s_tready), '0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    checkOutput("post reset m_tvalid", OutW'(m_tvalid), '0);
    checkOutput("post reset m_tdata", m_tdata, '0);
    checkOutput("post reset words_out", OutW'(words_out), '0);
    checkOutput("post reset padded_words", OutW'(padded_words), '0);
    expQ.push_back(128'h00000034_00000033_00000032_00000031);
    for (int i = 0; i < 4; i++) applyStimulus(32'h31 + InW'(i), 1'b0);
    waitDrain("reset drain");
    checkOutput("reset recovery words_out", OutW'(words_out), 128'd1);
    checkOutput("reset recovery padded_words", OutW'(padded_words), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
